// File: rtl/spi_register_bank.sv
// Register file behind the SPI slave: control, volume, sticky status and a coefficient RAM port.
// Optional macro SPI_REG_VOL_SHADOW_EN stages volume writes in shadows applied on frame_stb.
module spi_register_bank #(
  parameter int num_of_addr_bits = 7,
  parameter int num_of_data_bits = 16,
  parameter int coef_addr_bits = 8,
  parameter logic [num_of_data_bits-1:0] device_id = 16'hA0D1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        reg_read_stb,
  input  logic                        reg_write_stb,
  input  logic [num_of_addr_bits-1:0] spi_addr,
  input  logic [num_of_data_bits-1:0] spi_write_data,
  output logic [num_of_data_bits-1:0] spi_read_data,
  output logic                        dsp_enable,
  output logic                        mute,
  output logic [num_of_data_bits-1:0] volume_l,
  output logic [num_of_data_bits-1:0] volume_r,
  output logic [coef_addr_bits-1:0]   coef_addr,
  output logic [num_of_data_bits-1:0] coef_wr_data,
  output logic                        coef_wr_stb,
  input  logic [num_of_data_bits-1:0] coef_rd_data,
  input  logic                        clip_l,
  input  logic                        clip_r,
  input  logic                        fifo_ovf,
  input  logic                        frame_stb
);

  localparam logic [num_of_addr_bits-1:0] addr_id        = num_of_addr_bits'(0);
  localparam logic [num_of_addr_bits-1:0] addr_control   = num_of_addr_bits'(1);
  localparam logic [num_of_addr_bits-1:0] addr_status    = num_of_addr_bits'(2);
  localparam logic [num_of_addr_bits-1:0] addr_vol_l     = num_of_addr_bits'(3);
  localparam logic [num_of_addr_bits-1:0] addr_vol_r     = num_of_addr_bits'(4);
  localparam logic [num_of_addr_bits-1:0] addr_coef_addr = num_of_addr_bits'(5);
  localparam logic [num_of_addr_bits-1:0] addr_coef_data = num_of_addr_bits'(6);
  localparam logic [num_of_addr_bits-1:0] addr_scratch   = num_of_addr_bits'(7);
  localparam logic [num_of_data_bits-1:0] vol_reset = {1'b0, {(num_of_data_bits-1){1'b1}}};

  logic                        read_stb_d;
  logic                        write_stb_d;
  logic                        armed;
  logic                        rd_pulse;
  logic                        wr_pulse;
  logic [2:0]                  control;
  logic [2:0]                  status;
  logic [num_of_data_bits-1:0] scratch;
  logic [num_of_data_bits-1:0] vol_l_view;
  logic [num_of_data_bits-1:0] vol_r_view;
  logic [num_of_data_bits-1:0] read_mux;
  logic                        inc_pending;
  logic                        coef_data_hit;

  // armed masks the first cycle after reset so a strobe held through reset is never seen as an edge
  always_ff @(posedge clk) begin
    if (reset) begin
      read_stb_d  <= 1'b0;
      write_stb_d <= 1'b0;
      armed       <= 1'b0;
    end else begin
      read_stb_d  <= reg_read_stb;
      write_stb_d <= reg_write_stb;
      armed       <= 1'b1;
    end
  end

  assign rd_pulse      = reg_read_stb & ~read_stb_d & armed;
  assign wr_pulse      = reg_write_stb & ~write_stb_d & armed;
  assign coef_data_hit = (spi_addr == addr_coef_data);
  assign dsp_enable    = control[0];
  assign mute          = control[1];

  always_comb begin
    read_mux = '0;
    case (spi_addr)
      addr_id:        read_mux = device_id;
      addr_control:   read_mux[2:0] = control;
      addr_status:    read_mux[2:0] = status;
      addr_vol_l:     read_mux = vol_l_view;
      addr_vol_r:     read_mux = vol_r_view;
      addr_coef_addr: read_mux[coef_addr_bits-1:0] = coef_addr;
      addr_coef_data: read_mux = coef_rd_data;
      addr_scratch:   read_mux = scratch;
      default:        read_mux = '0;
    endcase
  end

  // a status pulse landing on the clearing cycle is OR-ed in after the clear, so it survives
  always_ff @(posedge clk) begin
    if (reset) begin
      spi_read_data <= '0;
      control       <= '0;
      status        <= '0;
      scratch       <= '0;
    end else begin
      if (rd_pulse) spi_read_data <= read_mux;
      status <= ((rd_pulse && spi_addr == addr_status) ? 3'b000 : status)
                | {fifo_ovf, clip_r, clip_l};
      if (wr_pulse && spi_addr == addr_control) control <= spi_write_data[2:0];
      if (wr_pulse && spi_addr == addr_scratch) scratch <= spi_write_data;
    end
  end

  // one shared pending flag, so a simultaneous read and write of COEF_DATA advances the address once
  always_ff @(posedge clk) begin
    if (reset) begin
      coef_addr    <= '0;
      coef_wr_data <= '0;
      coef_wr_stb  <= 1'b0;
      inc_pending  <= 1'b0;
    end else begin
      coef_wr_stb <= wr_pulse & coef_data_hit;
      if (wr_pulse && coef_data_hit) coef_wr_data <= spi_write_data;
      inc_pending <= (rd_pulse | wr_pulse) & coef_data_hit & control[2];
      if (wr_pulse && spi_addr == addr_coef_addr)
        coef_addr <= spi_write_data[coef_addr_bits-1:0];
      else if (inc_pending)
        coef_addr <= coef_addr + coef_addr_bits'(1);
    end
  end

`ifdef SPI_REG_VOL_SHADOW_EN
  logic [num_of_data_bits-1:0] shadow_l;
  logic [num_of_data_bits-1:0] shadow_r;

  // frame_stb copies the pre-edge shadows, so a write on the same cycle waits for the next frame
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_l <= vol_reset;
      shadow_r <= vol_reset;
      volume_l <= vol_reset;
      volume_r <= vol_reset;
    end else begin
      if (frame_stb) begin
        volume_l <= shadow_l;
        volume_r <= shadow_r;
      end
      if (wr_pulse && spi_addr == addr_vol_l) shadow_l <= spi_write_data;
      if (wr_pulse && spi_addr == addr_vol_r) shadow_r <= spi_write_data;
    end
  end

  assign vol_l_view = shadow_l;
  assign vol_r_view = shadow_r;
`else
  logic unused_frame_stb;

  always_ff @(posedge clk) begin
    if (reset) begin
      volume_l <= vol_reset;
      volume_r <= vol_reset;
    end else begin
      if (wr_pulse && spi_addr == addr_vol_l) volume_l <= spi_write_data;
      if (wr_pulse && spi_addr == addr_vol_r) volume_r <= spi_write_data;
    end
  end

  assign vol_l_view       = volume_l;
  assign vol_r_view       = volume_r;
  assign unused_frame_stb = frame_stb;
`endif

endmodule

// File: tb/tb_spi_register_bank.sv
// Self-checking bench for spi_register_bank: directed register-map checks plus randomized
// accesses compared every cycle against a register-map level model.
module tb_spi_register_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_read_stb;
  logic        reg_write_stb;
  logic [6:0]  spi_addr;
  logic [15:0] spi_write_data;
  logic [15:0] spi_read_data;
  logic        dsp_enable;
  logic        mute;
  logic [15:0] volume_l;
  logic [15:0] volume_r;
  logic [7:0]  coef_addr;
  logic [15:0] coef_wr_data;
  logic        coef_wr_stb;
  logic [15:0] coef_rd_data;
  logic        clip_l;
  logic        clip_r;
  logic        fifo_ovf;
  logic        frame_stb;

  int compared = 0;
  int mismatched = 0;
  bit rand_on = 1'b0;
  bit model_live = 1'b0;
  int stb_count;
  logic [7:0] stb_addr;

  always #5 clk = ~clk;

  spi_register_bank dut (
    .clk(clk), .reset(reset), .reg_read_stb(reg_read_stb), .reg_write_stb(reg_write_stb),
    .spi_addr(spi_addr), .spi_write_data(spi_write_data), .spi_read_data(spi_read_data),
    .dsp_enable(dsp_enable), .mute(mute), .volume_l(volume_l), .volume_r(volume_r),
    .coef_addr(coef_addr), .coef_wr_data(coef_wr_data), .coef_wr_stb(coef_wr_stb),
    .coef_rd_data(coef_rd_data), .clip_l(clip_l), .clip_r(clip_r), .fifo_ovf(fifo_ovf),
    .frame_stb(frame_stb)
  );

  // Coefficient RAM seen by the DUT: synchronous read, one clock of latency
  logic [15:0] ram [256];
  always @(posedge clk) begin
    if (coef_wr_stb) ram[coef_addr] <= coef_wr_data;
    coef_rd_data <= ram[coef_addr];
  end

  // Register-map model: state as the programmer sees it, updated once per clock
  logic [15:0] m_read_data, m_vol_l, m_vol_r, m_sh_l, m_sh_r, m_wr_data, m_scratch;
  logic [15:0] m_mem [256];
  logic [7:0]  m_coef_addr;
  logic [2:0]  m_ctrl, m_status;
  bit m_wr_stb, m_inc, m_prev_rd, m_prev_wr, m_rd, m_wr, m_next_inc;

  function automatic logic [15:0] model_read(input logic [6:0] a);
    case (a)
      7'd0: return 16'hA0D1;
      7'd1: return {13'd0, m_ctrl};
      7'd2: return {13'd0, m_status};
`ifdef SPI_REG_VOL_SHADOW_EN
      7'd3: return m_sh_l;
      7'd4: return m_sh_r;
`else
      7'd3: return m_vol_l;
      7'd4: return m_vol_r;
`endif
      7'd5: return {8'd0, m_coef_addr};
      7'd6: return m_mem[m_coef_addr];
      7'd7: return m_scratch;
      default: return 16'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_read_data = 0; m_ctrl = 0; m_status = 0; m_scratch = 0;
      m_vol_l = 16'h7FFF; m_vol_r = 16'h7FFF; m_sh_l = 16'h7FFF; m_sh_r = 16'h7FFF;
      m_coef_addr = 0; m_wr_data = 0; m_wr_stb = 0; m_inc = 0;
      m_prev_rd = reg_read_stb;
      m_prev_wr = reg_write_stb;
      model_live = 1'b1;
    end else begin
      m_rd = reg_read_stb && !m_prev_rd;
      m_wr = reg_write_stb && !m_prev_wr;
      m_prev_rd = reg_read_stb;
      m_prev_wr = reg_write_stb;
      m_next_inc = m_ctrl[2] && spi_addr == 7'd6 && (m_rd || m_wr);
      if (m_rd) m_read_data = model_read(spi_addr);
      if (m_rd && spi_addr == 7'd2) m_status = 0;
      m_status = m_status | {fifo_ovf, clip_r, clip_l};
      if (m_inc) m_coef_addr = m_coef_addr + 8'd1;
      m_wr_stb = 0;
`ifdef SPI_REG_VOL_SHADOW_EN
      if (frame_stb) begin
        m_vol_l = m_sh_l;
        m_vol_r = m_sh_r;
      end
`endif
      if (m_wr) begin
        case (spi_addr)
          7'd1: m_ctrl = spi_write_data[2:0];
`ifdef SPI_REG_VOL_SHADOW_EN
          7'd3: m_sh_l = spi_write_data;
          7'd4: m_sh_r = spi_write_data;
`else
          7'd3: m_vol_l = spi_write_data;
          7'd4: m_vol_r = spi_write_data;
`endif
          7'd5: m_coef_addr = spi_write_data[7:0];
          7'd6: begin
            m_wr_data = spi_write_data;
            m_wr_stb = 1;
            m_mem[m_coef_addr] = spi_write_data;
          end
          7'd7: m_scratch = spi_write_data;
          default: ;
        endcase
      end
      m_inc = m_next_inc;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (model_live && !reset) begin
      check_output("spi_read_data", spi_read_data, m_read_data);
      check_output("dsp_enable", dsp_enable, m_ctrl[0]);
      check_output("mute", mute, m_ctrl[1]);
      check_output("volume_l", volume_l, m_vol_l);
      check_output("volume_r", volume_r, m_vol_r);
      check_output("coef_addr", coef_addr, m_coef_addr);
      check_output("coef_wr_data", coef_wr_data, m_wr_data);
      check_output("coef_wr_stb", coef_wr_stb, m_wr_stb);
    end
  end

  // Every input change goes through here so side inputs have a single driver
  task automatic step();
    @(negedge clk);
    if (coef_wr_stb) begin
      stb_count++;
      stb_addr = coef_addr;
    end
    clip_l    = rand_on && ($urandom_range(0, 5) == 0);
    clip_r    = rand_on && ($urandom_range(0, 5) == 0);
    fifo_ovf  = rand_on && ($urandom_range(0, 7) == 0);
    frame_stb = rand_on && ($urandom_range(0, 3) == 0);
  endtask

  task automatic apply_stimulus(input bit rd, input bit wr, input logic [6:0] addr,
                                input logic [15:0] data, input int hold, input bit ovf_on_pulse);
    step();
    stb_count = 0;
    spi_addr = addr;
    spi_write_data = data;
    reg_read_stb = rd;
    reg_write_stb = wr;
    if (ovf_on_pulse) fifo_ovf = 1'b1;
    repeat (hold) step();
    reg_read_stb = 1'b0;
    reg_write_stb = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    logic [15:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 16'($urandom);
      ram[i] = v;
      m_mem[i] = v;
    end
    reset = 1'b1; reg_read_stb = 0; reg_write_stb = 0; spi_addr = 0; spi_write_data = 0;
    clip_l = 0; clip_r = 0; fifo_ovf = 0; frame_stb = 0;
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    check_output("reset_read_data", spi_read_data, 16'h0000);
    check_output("reset_dsp_enable", dsp_enable, 1'b0);
    check_output("reset_coef_addr", coef_addr, 8'h00);
    apply_stimulus(1, 0, 7'h00, 16'h0000, 1, 0);
    check_output("id_read", spi_read_data, 16'hA0D1);
    check_output("reset_volume_l", volume_l, 16'h7FFF);
    check_output("reset_volume_r", volume_r, 16'h7FFF);

    apply_stimulus(0, 1, 7'h01, 16'hFFFF, 5, 0);
    check_output("ctrl_dsp_enable", dsp_enable, 1'b1);
    check_output("ctrl_mute", mute, 1'b1);
    apply_stimulus(1, 0, 7'h01, 16'h0000, 1, 0);
    check_output("ctrl_read", spi_read_data, 16'h0007);

    step(); clip_l = 1'b1; step();
    apply_stimulus(1, 0, 7'h02, 16'h0000, 1, 0);
    check_output("status_clip_l", spi_read_data, 16'h0001);
    apply_stimulus(1, 0, 7'h02, 16'h0000, 1, 1);
    check_output("status_cleared", spi_read_data, 16'h0000);
    apply_stimulus(1, 0, 7'h02, 16'h0000, 1, 0);
    check_output("status_ovf_wins", spi_read_data, 16'h0004);

    apply_stimulus(0, 1, 7'h05, 16'h00FF, 1, 0);
    apply_stimulus(0, 1, 7'h06, 16'h1234, 5, 0);
    check_output("coef_stb_once", stb_count, 1);
    check_output("coef_stb_addr_ff", stb_addr, 8'hFF);
    check_output("coef_wrap", coef_addr, 8'h00);
    apply_stimulus(0, 1, 7'h06, 16'h5678, 1, 0);
    check_output("coef_stb_addr_00", stb_addr, 8'h00);
    check_output("coef_final_addr", coef_addr, 8'h01);
    apply_stimulus(0, 1, 7'h05, 16'hABFF, 1, 0);
    apply_stimulus(1, 0, 7'h06, 16'h0000, 1, 0);
    check_output("coef_read_ff", spi_read_data, 16'h1234);
    apply_stimulus(1, 0, 7'h06, 16'h0000, 1, 0);
    check_output("coef_read_00", spi_read_data, 16'h5678);
    apply_stimulus(1, 0, 7'h05, 16'h0000, 1, 0);
    check_output("coef_addr_read", spi_read_data, 16'h0001);

    apply_stimulus(0, 1, 7'h03, 16'h0100, 1, 0);
`ifdef SPI_REG_VOL_SHADOW_EN
    check_output("vol_l_held", volume_l, 16'h7FFF);
    step(); frame_stb = 1'b1; step(); step();
`endif
    check_output("vol_l_written", volume_l, 16'h0100);

    apply_stimulus(0, 1, 7'h07, 16'hBEEF, 1, 0);
    apply_stimulus(1, 0, 7'h7F, 16'h0000, 1, 0);
    check_output("unmapped_read", spi_read_data, 16'h0000);
    apply_stimulus(0, 1, 7'h7F, 16'hFFFF, 1, 0);
    apply_stimulus(1, 1, 7'h07, 16'h1111, 1, 0);
    check_output("rw_same_clk_old", spi_read_data, 16'hBEEF);
    apply_stimulus(1, 0, 7'h07, 16'h0000, 1, 0);
    check_output("rw_same_clk_new", spi_read_data, 16'h1111);

    step();
    spi_addr = 7'h00; reg_read_stb = 1'b1; reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    repeat (4) step();
    check_output("held_strobe_no_access", spi_read_data, 16'h0000);
    reg_read_stb = 1'b0;
    repeat (2) step();

    rand_on = 1'b1;
    for (int t = 0; t < 600; t++) begin
      bit rd, wr;
      logic [6:0] a;
      int sel;
      sel = $urandom_range(0, 2);
      rd = (sel != 1);
      wr = (sel != 0);
      a = ($urandom_range(0, 9) < 8) ? 7'($urandom_range(0, 7)) : 7'($urandom);
      apply_stimulus(rd, wr, a, 16'($urandom), $urandom_range(1, 4), 0);
    end
    rand_on = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
